axis_packet_merger: RTL and testbench

AXIS_PACKET_MERGER -- requirements
Module: axis_packet_merger

---
 rtl/axis_packet_merger.sv | 214 +++++++++++++++++++++
 tb/tb_axis_packet_merger.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_merger.sv
// -----------------------------------------------------------------------------
// axis_packet_merger
//
// Merges pckt_count consecutive input packets of pckt_len beats each into a
// single AXI-Stream output packet. Input tlast is checked against the expected
// packet length and then stripped, except that the beat which ends the merged
// packet carries m_axis_tlast. If the observed length disagrees with pckt_len,
// the offending beat is forwarded with m_axis_tlast=1 to close the output
// packet, and the FSM reports an error.
//
// Optional feature macro: AXIS_PACKET_MERGER_LOCK_EN
//   defined   : lock=1 freezes FSM state and counters. No beats are accepted
//               while frozen, external_error still forces ERR, and the output
//               buffer keeps draining.
//   undefined : the lock port is present but ignored.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   operation_start           start request, sampled in IDLE and END
//   pckt_len, pckt_count      beats per input packet and packets per merge,
//                             latched at start
//   lock                      freeze request (see macro above)
//   external_error            forces ERR on the next cycle
//   operation_busy            high while in OPE
//   operation_complete        1-cycle pulse on entering END
//   operation_error           1-cycle pulse on entering ERR
//   transmission              high in the cycle after an output handshake
//   s_axis_*                  packetized input stream
//   m_axis_*                  merged output stream, fed by a 2-entry buffer
// -----------------------------------------------------------------------------
module axis_packet_merger #(
    parameter int DATA_WIDTH = 16,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int PCKT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  operation_start,
    input  logic [PCKT_WIDTH-1:0] pckt_len,
    input  logic [PCKT_WIDTH-1:0] pckt_count,
    input  logic                  lock,
    input  logic                  external_error,
    output logic                  operation_busy,
    output logic                  operation_complete,
    output logic                  operation_error,
    output logic                  transmission,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPE,
        S_END,
        S_ERR
    } state_t;

    localparam logic [PCKT_WIDTH-1:0] ONE = PCKT_WIDTH'(1);

    state_t                state;
    state_t                next_state;

    logic [PCKT_WIDTH-1:0] len_q;
    logic [PCKT_WIDTH-1:0] count_q;
    logic [PCKT_WIDTH-1:0] beat_cnt;
    logic [PCKT_WIDTH-1:0] pkt_cnt;

    logic                  hold;
    logic                  accept;
    logic                  pop;
    logic                  start_ok;
    logic                  last_in_pkt;
    logic                  last_overall;
    logic                  len_mismatch;
    logic                  out_last;

    // Output buffer: two entries addressed by 1-bit pointers.
    logic [DATA_WIDTH-1:0] buf_data [0:1];
    logic [KEEP_WIDTH-1:0] buf_keep [0:1];
    logic [1:0]            buf_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            buf_count;

`ifdef AXIS_PACKET_MERGER_LOCK_EN
    assign hold = lock;
`else
    logic unused_lock;
    assign unused_lock = lock;
    assign hold        = 1'b0;
`endif

    // Input side. Beats are refused while frozen so the held counters stay
    // consistent with what has entered the buffer.
    assign s_axis_tready = operation_busy && (buf_count != 2'd2) && !hold;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Output side: head of the buffer, held stable until the handshake.
    assign m_axis_tvalid = (buf_count != 2'd0);
    assign m_axis_tdata  = buf_data[rd_ptr];
    assign m_axis_tkeep  = buf_keep[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && buf_last[rd_ptr];
    assign pop           = m_axis_tvalid && m_axis_tready;

    // Beat classification against the latched geometry.
    assign last_in_pkt  = (beat_cnt == len_q - ONE);
    assign last_overall = last_in_pkt && (pkt_cnt == count_q - ONE);
    assign len_mismatch = (s_axis_tlast != last_in_pkt);
    assign out_last     = last_overall || len_mismatch;
    assign start_ok     = (pckt_len != '0) && (pckt_count != '0);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        if (external_error) begin
            next_state = S_ERR;
        end else if (!hold) begin
            case (state)
                S_IDLE, S_END: begin
                    if (operation_start) next_state = start_ok ? S_OPE : S_ERR;
                    else                 next_state = S_IDLE;
                end
                S_OPE: begin
                    if (accept) begin
                        if (len_mismatch)      next_state = S_ERR;
                        else if (last_overall) next_state = S_END;
                    end
                end
                S_ERR:   next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: state and anything else that must hold its value across cycles is
    // updated with non-blocking assignments so every register samples the
    // pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            operation_busy     <= 1'b0;
            operation_complete <= 1'b0;
            operation_error    <= 1'b0;
            transmission       <= 1'b0;
        end else begin
            state              <= next_state;
            operation_busy     <= (next_state == S_OPE);
            operation_complete <= (next_state == S_END) && (state != S_END);
            operation_error    <= (next_state == S_ERR) && (state != S_ERR);
            transmission       <= pop;
        end
    end

    // Geometry latch and beat/packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            count_q  <= '0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (!hold && operation_start &&
                     (state == S_IDLE || state == S_END)) begin
            len_q    <= pckt_len;
            count_q  <= pckt_count;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (accept) begin
            if (last_in_pkt) begin
                beat_cnt <= '0;
                pkt_cnt  <= pkt_cnt + ONE;
            end else begin
                beat_cnt <= beat_cnt + ONE;
            end
        end
    end

    // Buffer occupancy and pointers. Emptying the buffer on reset is enough to
    // discard any partially merged packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // NOTE: the buffer payload has no reset; an entry is only observed once
    // buf_count marks it valid, and m_axis_tlast is gated by m_axis_tvalid.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data[wr_ptr] <= s_axis_tdata;
            buf_keep[wr_ptr] <= s_axis_tkeep;
            buf_last[wr_ptr] <= out_last;
        end
    end

endmodule

// File: tb/tb_axis_packet_merger.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_merger
//
// Randomized bench for axis_packet_merger. Each operation is described by its
// geometry (length, count) and an optional corrupted tlast position; the
// expected output beats are derived from those rules, queued, and compared by
// an independent monitor whenever the DUT completes an output handshake.
// -----------------------------------------------------------------------------
module tb_axis_packet_merger;

    localparam int DW = 16;
    localparam int KW = (DW + 7) / 8;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          operation_start;
    logic [PW-1:0] pckt_len;
    logic [PW-1:0] pckt_count;
    logic          lock;
    logic          external_error;
    logic          operation_busy;
    logic          operation_complete;
    logic          operation_error;
    logic          transmission;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    axis_packet_merger #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .PCKT_WIDTH(PW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .operation_start    (operation_start),
        .pckt_len           (pckt_len),
        .pckt_count         (pckt_count),
        .lock               (lock),
        .external_error     (external_error),
        .operation_busy     (operation_busy),
        .operation_complete (operation_complete),
        .operation_error    (operation_error),
        .transmission       (transmission),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests    = 0;
    int    n_fail     = 0;
    int    n_complete = 0;
    int    n_error    = 0;
    int    ready_mode = 0;   // 0: always ready, 1: toggle, 2: random, 3: stalled

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expire(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got timeout, expected event", name);
    endtask

    // Output-ready pattern generator.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: samples on the falling edge, compares handshaked beats against
    // the expectation queue, tracks status pulses and the transmission flag.
    initial begin
        beat_t e;
        bit    prev_hs;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hs = 1'b0;
            end else begin
                check("transmission", transmission, prev_hs);
                if (operation_complete) n_complete++;
                if (operation_error)    n_error++;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat",
                                 m_axis_tdata, m_axis_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_axis_tdata, e.data);
                        check("out_keep", m_axis_tkeep, e.keep);
                        check("out_last", m_axis_tlast, e.last);
                    end
                end
                prev_hs = m_axis_tvalid && m_axis_tready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_op(input int len, input int cnt);
        pckt_len        = PW'(len);
        pckt_count      = PW'(cnt);
        operation_start = 1'b1;
        idle(1);
        operation_start = 1'b0;
    endtask

    // Presents one beat and returns once it has been accepted.
    task automatic send_beat(input beat_t b);
        int t;
        t             = 0;
        s_axis_tdata  = b.data;
        s_axis_tkeep  = b.keep;
        s_axis_tlast  = b.last;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            t++;
            if (t > 200) begin
                expire("send_beat");
                break;
            end
        end
        idle(1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            idle(1);
            t++;
        end
        check("drain", exp_q.size(), 0);
        idle(3);
    endtask

    // Reference model: input beat i has tlast set when it is the last of its
    // input packet, inverted at bad_at. The first wrong tlast ends the
    // operation with an error; otherwise len*cnt beats complete it. Either
    // way the final forwarded beat is the only one with tlast.
    task automatic build_op(input int len, input int cnt, input int bad_at,
                            output beat_t stim[$], output bit exp_err);
        int    total;
        int    n_send;
        beat_t b;
        beat_t o;
        total   = len * cnt;
        exp_err = (bad_at >= 0) && (bad_at < total);
        n_send  = exp_err ? bad_at + 1 : total;
        stim.delete();
        for (int i = 0; i < n_send; i++) begin
            b.data = DW'($urandom());
            b.keep = KW'($urandom());
            b.last = ((i % len) == len - 1) ^ (i == bad_at);
            stim.push_back(b);
            o      = b;
            o.last = (i == n_send - 1);
            exp_q.push_back(o);
        end
    endtask

    task automatic run_op(input string name, input int len, input int cnt,
                          input int bad_at, input int mode);
        beat_t stim[$];
        bit    exp_err;
        int    c0;
        int    e0;
        ready_mode = mode;
        c0 = n_complete;
        e0 = n_error;
        build_op(len, cnt, bad_at, stim, exp_err);
        start_op(len, cnt);
        foreach (stim[i]) begin
            send_beat(stim[i]);
            idle($urandom_range(0, 2));
        end
        wait_drain();
        check({name, "_complete"}, n_complete - c0, exp_err ? 0 : 1);
        check({name, "_error"}, n_error - e0, exp_err ? 1 : 0);
        check({name, "_busy"}, operation_busy, 1'b0);
        check({name, "_s_tready"}, s_axis_tready, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_s_tready"}, s_axis_tready, 1'b0);
        check({name, "_m_tvalid"}, m_axis_tvalid, 1'b0);
        check({name, "_m_tlast"}, m_axis_tlast, 1'b0);
        check({name, "_busy"}, operation_busy, 1'b0);
        check({name, "_complete"}, operation_complete, 1'b0);
        check({name, "_error"}, operation_error, 1'b0);
        check({name, "_transmission"}, transmission, 1'b0);
    endtask

    initial begin
        beat_t stim[$];
        bit    exp_err;
        int    c0;
        int    e0;
        int    acc;

        rst             = 1'b1;
        operation_start = 1'b0;
        pckt_len        = '0;
        pckt_count      = '0;
        lock            = 1'b0;
        external_error  = 1'b0;
        s_axis_tdata    = '0;
        s_axis_tkeep    = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        idle(3);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Nominal merge, then with a toggling output ready.
        run_op("merge_4x3", 4, 3, -1, 0);
        run_op("merge_4x3_toggle", 4, 3, -1, 1);

        // Early tlast on the third beat of the first packet.
        run_op("early_tlast", 4, 3, 2, 0);

        // Missing tlast on the final beat, single-beat packets.
        run_op("missing_last", 2, 2, 3, 0);
        run_op("len1", 1, 3, -1, 2);

        // Zero packet count: error and nothing accepted.
        ready_mode = 0;
        e0 = n_error;
        start_op(4, 0);
        s_axis_tvalid = 1'b1;
        acc = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_axis_tready) acc++;
        end
        idle(1);
        s_axis_tvalid = 1'b0;
        check("zero_count_accepts", acc, 0);
        check("zero_count_error", n_error - e0, 1);
        idle(2);

        // External error after the fifth beat of a 12-beat operation.
        ready_mode = 0;
        c0 = n_complete;
        e0 = n_error;
        build_op(4, 3, 4, stim, exp_err);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            stim[i].last = ((i % 4) == 3);
            exp_q.push_back('{data: stim[i].data, keep: stim[i].keep, last: 1'b0});
        end
        start_op(4, 3);
        for (int i = 0; i < 5; i++) send_beat(stim[i]);
        external_error = 1'b1;
        idle(1);
        external_error = 1'b0;
        @(negedge clk);
        check("ext_err_pulse", operation_error, 1'b1);
        check("ext_err_busy", operation_busy, 1'b0);
        idle(1);
        wait_drain();
        check("ext_err_count", n_error - e0, 1);
        check("ext_err_complete", n_complete - c0, 0);

        // Freeze in the middle of an operation, then resume.
        ready_mode = 0;
        c0 = n_complete;
        e0 = n_error;
        build_op(4, 3, -1, stim, exp_err);
        start_op(4, 3);
        for (int i = 0; i < 3; i++) send_beat(stim[i]);
`ifdef AXIS_PACKET_MERGER_LOCK_EN
        lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("lock_busy_held", operation_busy, 1'b1);
            idle(1);
        end
        lock = 1'b0;
`else
        lock = 1'b1;
`endif
        for (int i = 3; i < 12; i++) send_beat(stim[i]);
        lock = 1'b0;
        wait_drain();
        check("lock_complete", n_complete - c0, 1);
        check("lock_error", n_error - e0, 0);

        // Reset in the middle of a packet discards buffered beats.
        ready_mode = 3;
        idle(1);
        build_op(4, 3, -1, stim, exp_err);
        exp_q.delete();
        start_op(4, 3);
        send_beat(stim[0]);
        send_beat(stim[1]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        ready_mode = 0;
        idle(6);
        check("midreset_no_output", m_axis_tvalid, 1'b0);

        // Randomized operations.
        for (int k = 0; k < 10; k++) begin
            int len;
            int cnt;
            int bad;
            len = $urandom_range(1, 5);
            cnt = $urandom_range(1, 4);
            bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len * cnt - 1) : -1;
            run_op("random", len, cnt, bad, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
